// File: rtl/sram_1rw1r_param.sv
// Parametrised single-clock 1RW+1R SRAM with masked writes, 1- or 2-cycle read
// latency, held outputs, read-valid flags and port-0 -> port-1 write forwarding.
module sram_1rw1r_param #(
  parameter  int DATA_WIDTH   = 32,
  parameter  int DEPTH        = 256,
  parameter  int MASK_GRAN    = 8,
  parameter  int READ_LATENCY = 1,
  parameter  int FORWARD      = 1,
  localparam int ADDR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NUM_WMASKS   = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  coll1
);

  if ((DATA_WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
    $fatal(1, "sram_1rw1r_param: DATA_WIDTH must be a multiple of MASK_GRAN");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "sram_1rw1r_param: READ_LATENCY must be 1 or 2");
  end

  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_rng0, in_rng1;
  logic                  wr_en, rd0_req, rd1_req, coll;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] rd0_word, rd1_old, rd1_word;

  // Addresses past DEPTH have no storage: writes drop, reads return zero.
  assign in_rng0 = ({1'b0, addr0} < DEPTH_EXT);
  assign in_rng1 = ({1'b0, addr1} < DEPTH_EXT);
  assign wr_en   = ~csb0 & ~web0 & in_rng0;
  assign rd0_req = ~csb0 & web0;
  assign rd1_req = ~csb1;
  assign coll    = wr_en & rd1_req & in_rng1 & (addr0 == addr1);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      lane_mask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wmask0[i]}};
    end
  end

  always_comb begin
    rd0_word = in_rng0 ? mem[addr0] : '0;
    rd1_old  = in_rng1 ? mem[addr1] : '0;
    rd1_word = rd1_old;
    if (FORWARD != 0 && coll) begin
      rd1_word = (rd1_old & ~lane_mask) | (din0 & lane_mask);
    end
  end

  // NOTE: the array has no reset; only the read pipeline is cleared by rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*MASK_GRAN +: MASK_GRAN] <= din0[i*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  logic                  s1_v0, s1_v1, s1_c1;
  logic [DATA_WIDTH-1:0] s1_d0, s1_d1;

  // NOTE: sequential state uses non-blocking assignments so the array read above
  // sees pre-edge contents and stages shift without ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v0 <= 1'b0;
      s1_d0 <= '0;
      s1_v1 <= 1'b0;
      s1_c1 <= 1'b0;
      s1_d1 <= '0;
    end else begin
      s1_v0 <= rd0_req;
      s1_v1 <= rd1_req;
      s1_c1 <= coll;
      if (rd0_req) s1_d0 <= rd0_word;
      if (rd1_req) s1_d1 <= rd1_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_v0, s2_v1, s2_c1;
    logic [DATA_WIDTH-1:0] s2_d0, s2_d1;

    // Data registers load only on a valid stage so outputs hold between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_v0 <= 1'b0;
        s2_d0 <= '0;
        s2_v1 <= 1'b0;
        s2_c1 <= 1'b0;
        s2_d1 <= '0;
      end else begin
        s2_v0 <= s1_v0;
        s2_v1 <= s1_v1;
        s2_c1 <= s1_c1;
        if (s1_v0) s2_d0 <= s1_d0;
        if (s1_v1) s2_d1 <= s1_d1;
      end
    end

    assign dout0       = s2_d0;
    assign dout0_valid = s2_v0;
    assign dout1       = s2_d1;
    assign dout1_valid = s2_v1;
    assign coll1       = s2_c1;
  end else begin : g_lat1
    assign dout0       = s1_d0;
    assign dout0_valid = s1_v0;
    assign dout1       = s1_d1;
    assign dout1_valid = s1_v1;
    assign coll1       = s1_c1;
  end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Scoreboard bench: two SRAM configurations share one stimulus stream; a monitor
// pops expected words whenever a port raises its valid flag.
module tb_sram_1rw1r_param;

  localparam int LAT_A = 1;
  localparam int LAT_B = 2;

  logic        clk, rst_n;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [63:0] din0;

  logic [31:0] a_d0, a_d1;
  logic        a_v0, a_v1, a_c1;
  logic [63:0] b_d0, b_d1;
  logic        b_v0, b_v1, b_c1;

  // u_a: 32x256, byte lanes, 1-cycle, forwarding on.
  sram_1rw1r_param u_a (
    .clk(clk), .rst_n(rst_n),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0[31:0]),
    .dout0(a_d0), .dout0_valid(a_v0),
    .csb1(csb1), .addr1(addr1), .dout1(a_d1), .dout1_valid(a_v1), .coll1(a_c1)
  );

  // u_b: 64x200, 16-bit lanes, 2-cycle, forwarding off.
  sram_1rw1r_param #(
    .DATA_WIDTH(64), .DEPTH(200), .MASK_GRAN(16), .READ_LATENCY(LAT_B), .FORWARD(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(b_d0), .dout0_valid(b_v0),
    .csb1(csb1), .addr1(addr1), .dout1(b_d1), .dout1_valid(b_v1), .coll1(b_c1)
  );

  typedef struct {
    string       tag;
    logic [63:0] d;
    logic        c;
    int          t;
  } exp_t;

  exp_t q_a0[$], q_a1[$], q_b0[$], q_b1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input int i);
    logic [7:0] a;
    a = i[7:0];
    return {a, 8'h11, ~a, 8'h22, a ^ 8'h55, 8'h33, a ^ 8'hAA, 8'h44};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: valid asserted with no read outstanding (cycle %0d)", nm, cyc);
  endtask

  task automatic mon_cmp(input string nm, input logic [63:0] act, input bit has_c,
                         input logic c, input exp_t e);
    check({nm, " ", e.tag, " data"}, act, e.d);
    check({nm, " ", e.tag, " cycle"}, 64'(cyc), 64'(e.t));
    if (has_c) check({nm, " ", e.tag, " coll"}, {63'b0, c}, {63'b0, e.c});
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (a_v0) begin
      if (q_a0.size() == 0) unexpected("a0");
      else begin e = q_a0.pop_front(); mon_cmp("a0", {32'h0, a_d0}, 1'b0, 1'b0, e); end
    end
    if (a_v1) begin
      if (q_a1.size() == 0) unexpected("a1");
      else begin e = q_a1.pop_front(); mon_cmp("a1", {32'h0, a_d1}, 1'b1, a_c1, e); end
    end
    if (b_v0) begin
      if (q_b0.size() == 0) unexpected("b0");
      else begin e = q_b0.pop_front(); mon_cmp("b0", b_d0, 1'b0, 1'b0, e); end
    end
    if (b_v1) begin
      if (q_b1.size() == 0) unexpected("b1");
      else begin e = q_b1.pop_front(); mon_cmp("b1", b_d1, 1'b1, b_c1, e); end
    end
  end

  // Called in the cycle the request is driven; the sampling edge is the next one.
  task automatic push(input int port, input string tag, input logic [63:0] ea, input logic ca,
                      input bit do_b, input logic [63:0] eb, input logic cb);
    exp_t e;
    e.tag = tag;
    e.t   = cyc + LAT_A;
    e.d   = ea;
    e.c   = ca;
    if (port == 0) q_a0.push_back(e); else q_a1.push_back(e);
    if (do_b) begin
      e.t = cyc + LAT_B;
      e.d = eb;
      e.c = cb;
      if (port == 0) q_b0.push_back(e); else q_b1.push_back(e);
    end
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [3:0] m, input logic [7:0] a0,
                       input logic [63:0] d, input logic c1, input logic [7:0] a1);
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 4'h0, 8'h0, 64'h0, 1'b1, 8'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string nm);
    check({nm, " a dout"}, {a_d0, a_d1}, 64'h0);
    check({nm, " a flags"}, {61'b0, a_v0, a_v1, a_c1}, 64'h0);
    check({nm, " b dout0"}, b_d0, 64'h0);
    check({nm, " b dout1"}, b_d1, 64'h0);
    check({nm, " b flags"}, {61'b0, b_v0, b_v1, b_c1}, 64'h0);
  endtask

  initial begin
    logic [63:0] eb;
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 4'h0, 8'd3, 64'h0, 1'b0, 8'd4);
    repeat (3) begin
      @(negedge clk);
      check_zero("reset");
    end
    tick();
    rst_n = 1'b1;
    idle();

    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b0, 4'hF, 8'(i), pat(i), 1'b1, 8'h0);
      tick();
    end

    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 4'h0, 8'(i), 64'h0, 1'b0, 8'(255 - i));
      eb = (i < 200) ? pat(i) : 64'h0;
      push(0, "stream", {32'h0, pat(i)[31:0]}, 1'b0, 1'b1, eb, 1'b0);
      eb = ((255 - i) < 200) ? pat(255 - i) : 64'h0;
      push(1, "stream", {32'h0, pat(255 - i)[31:0]}, 1'b0, 1'b1, eb, 1'b0);
      tick();
    end

    idle();
    repeat (3) tick();
    @(negedge clk);
    #1;
    check("hold a dout0", {32'h0, a_d0}, {32'h0, pat(255)[31:0]});
    check("hold a dout1", {32'h0, a_d1}, {32'h0, pat(0)[31:0]});
    check("hold b dout0", b_d0, 64'h0);
    check("hold b dout1", b_d1, pat(0));
    check("hold valids", {60'b0, a_v0, a_v1, b_v0, b_v1}, 64'h0);

    // Masked writes to word 5, then read-after-write on the next edge.
    drive(1'b0, 1'b0, 4'b1111, 8'd5, 64'h0123_4567_AABB_CCDD, 1'b1, 8'h0);
    tick();
    drive(1'b0, 1'b0, 4'b0101, 8'd5, 64'h89AB_CDEF_1122_3344, 1'b1, 8'h0);
    tick();
    drive(1'b0, 1'b1, 4'h0, 8'd5, 64'h0, 1'b1, 8'h0);
    push(0, "mask", 64'hAA22_CC44, 1'b0, 1'b1, 64'h0123_CDEF_AABB_3344, 1'b0);
    tick();

    // Collision on word 9: u_a forwards, u_b returns the old word.
    drive(1'b0, 1'b0, 4'b1111, 8'd9, 64'h0, 1'b1, 8'h0);
    tick();
    drive(1'b0, 1'b0, 4'b1100, 8'd9, 64'hFFFF_0000_FFFF_0000, 1'b0, 8'd9);
    push(1, "coll", 64'hFFFF_0000, 1'b1, 1'b1, 64'h0, 1'b1);
    tick();
    drive(1'b0, 1'b1, 4'h0, 8'd9, 64'h0, 1'b0, 8'd9);
    push(0, "post-coll", 64'hFFFF_0000, 1'b0, 1'b1, 64'hFFFF_0000_0000_0000, 1'b0);
    push(1, "post-coll", 64'hFFFF_0000, 1'b0, 1'b1, 64'hFFFF_0000_0000_0000, 1'b0);
    tick();

    // Address 210 is real storage in u_a but out of range in u_b.
    drive(1'b0, 1'b0, 4'b1111, 8'd210, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 8'd210);
    push(1, "oor-wr", 64'hCAFE_F00D, 1'b1, 1'b1, 64'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 4'h0, 8'd210, 64'h0, 1'b0, 8'd82);
    push(0, "oor-rd", 64'hCAFE_F00D, 1'b0, 1'b1, 64'h0, 1'b0);
    push(1, "alias", {32'h0, pat(82)[31:0]}, 1'b0, 1'b1, pat(82), 1'b0);
    tick();

    // Same-address read on both ports, then reset while u_b still holds it in flight.
    drive(1'b0, 1'b1, 4'h0, 8'd7, 64'h0, 1'b0, 8'd7);
    push(0, "pre-rst", {32'h0, pat(7)[31:0]}, 1'b0, 1'b0, 64'h0, 1'b0);
    push(1, "pre-rst", {32'h0, pat(7)[31:0]}, 1'b0, 1'b0, 64'h0, 1'b0);
    tick();
    idle();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("mid-read reset");
    #1;
    rst_n = 1'b1;
    repeat (5) tick();

    check("a0 pending", 64'(q_a0.size()), 64'h0);
    check("a1 pending", 64'(q_a1.size()), 64'h0);
    check("b0 pending", 64'(q_b0.size()), 64'h0);
    check("b1 pending", 64'(q_b1.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
